// File: rtl/game_round_ctrl.sv
// Round sequencer for the reflex trainer: idle, countdown, play, over.
// Optional macro BEST_SCORE_EN adds a best_score output register.
module game_round_ctrl #(
    parameter int CLK_HZ            = 100000000,
    parameter int GAME_SECONDS      = 30,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int SCORE_W           = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_btn,
    input  logic               abort_btn,
    input  logic               hit,
    input  logic               miss,
    input  logic               sec_tick,
    input  logic [4:0]         elapsed_time,
    output logic               timer_start,
    output logic [1:0]         state,
    output logic [1:0]         countdown,
    output logic [4:0]         time_left,
    output logic [SCORE_W-1:0] score,
`ifdef BEST_SCORE_EN
    output logic [SCORE_W-1:0] best_score,
`endif
    output logic               game_over
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
    localparam logic [5:0] GS6 = 6'(GAME_SECONDS);
    localparam logic [1:0] CD_LOAD = 2'(COUNTDOWN_SECONDS);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        COUNTDOWN = 2'b01,
        PLAY      = 2'b10,
        OVER      = 2'b11
    } state_t;

    state_t             cur, cur_n;
    logic [PW-1:0]      pre, pre_n;
    logic [1:0]         cd_n;
    logic [4:0]         tl_n;
    logic [SCORE_W-1:0] score_n;
    logic               ts_n, go_n;
    logic [5:0]         diff;
    logic               play_end;
`ifdef BEST_SCORE_EN
    logic [SCORE_W-1:0] best_n;
`endif

    assign state    = cur;
    assign diff     = GS6 - {1'b0, elapsed_time};
    assign play_end = sec_tick && ({1'b0, elapsed_time} >= GS6);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur         <= IDLE;
            pre         <= '0;
            countdown   <= '0;
            time_left   <= 5'(GAME_SECONDS);
            score       <= '0;
            timer_start <= 1'b0;
            game_over   <= 1'b0;
`ifdef BEST_SCORE_EN
            best_score  <= '0;
`endif
        end else begin
            cur         <= cur_n;
            pre         <= pre_n;
            countdown   <= cd_n;
            time_left   <= tl_n;
            score       <= score_n;
            timer_start <= ts_n;
            game_over   <= go_n;
`ifdef BEST_SCORE_EN
            best_score  <= best_n;
`endif
        end
    end

    always_comb begin
        cur_n   = cur;
        pre_n   = pre;
        cd_n    = countdown;
        score_n = score;
        go_n    = 1'b0;
`ifdef BEST_SCORE_EN
        best_n  = best_score;
`endif
        unique case (cur)
            IDLE, OVER: begin
                if (start_btn) begin
                    cur_n   = COUNTDOWN;
                    cd_n    = CD_LOAD;
                    score_n = '0;
                    pre_n   = '0;
                end
            end
            COUNTDOWN: begin
                if (pre == PRE_MAX) begin
                    pre_n = '0;
                    cd_n  = countdown - 2'd1;
                    if (countdown == 2'd1)
                        cur_n = PLAY;
                end else begin
                    pre_n = pre + PW'(1);
                end
            end
            PLAY: begin
                if (hit && !miss && score != '1)
                    score_n = score + SCORE_W'(1);
                else if (miss && !hit && score != '0)
                    score_n = score - SCORE_W'(1);
                if (play_end) begin
                    cur_n = OVER;
                    go_n  = 1'b1;
`ifdef BEST_SCORE_EN
                    if (score_n > best_score)
                        best_n = score_n;
`endif
                end
            end
            default: ;
        endcase

        // Abort wins over start and over the end-of-play transition.
        if (abort_btn && cur != IDLE) begin
            cur_n   = IDLE;
            score_n = '0;
            cd_n    = '0;
            pre_n   = '0;
            go_n    = 1'b0;
`ifdef BEST_SCORE_EN
            best_n  = best_score;
`endif
        end

        ts_n = (cur_n == PLAY);
        unique case (cur_n)
            PLAY:    tl_n = diff[5] ? 5'd0 : diff[4:0];
            OVER:    tl_n = 5'd0;
            default: tl_n = 5'(GAME_SECONDS);
        endcase
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Scoreboard bench for game_round_ctrl with a small behavioural model.
// Build with BEST_SCORE_EN defined to also cover best_score.
module tb_game_round_ctrl;

    localparam int CLK_HZ = 4;
    localparam int GS     = 3;
    localparam int CS     = 2;
    localparam int SW     = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_btn = 1'b0, abort_btn = 1'b0;
    logic          hit = 1'b0, miss = 1'b0, sec_tick = 1'b0;
    logic [4:0]    elapsed_time = '0;
    logic          timer_start, game_over;
    logic [1:0]    state, countdown;
    logic [4:0]    time_left;
    logic [SW-1:0] score;
`ifdef BEST_SCORE_EN
    logic [SW-1:0] best_score;
`endif

    game_round_ctrl #(
        .CLK_HZ(CLK_HZ), .GAME_SECONDS(GS),
        .COUNTDOWN_SECONDS(CS), .SCORE_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_btn(start_btn), .abort_btn(abort_btn),
        .hit(hit), .miss(miss), .sec_tick(sec_tick),
        .elapsed_time(elapsed_time),
        .timer_start(timer_start), .state(state),
        .countdown(countdown), .time_left(time_left),
        .score(score),
`ifdef BEST_SCORE_EN
        .best_score(best_score),
`endif
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st, cd, tl, sc, ts, go, best;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_errors = 0;

    // model state
    int m_st = 0, m_cd = 0, m_pre = 0, m_sc = 0, m_best = 0;
    int m_tl = GS, m_ts = 0, m_go = 0;
    int tel = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input bit r, s, a, h, m, t, input int el);
        exp_t e;
        m_go = 0;
        if (!r) begin
            m_st = 0; m_cd = 0; m_pre = 0; m_sc = 0; m_best = 0;
        end else if (a && m_st != 0) begin
            m_st = 0; m_sc = 0; m_cd = 0; m_pre = 0;
        end else begin
            case (m_st)
                0, 3: if (s) begin
                    m_st = 1; m_cd = CS; m_sc = 0; m_pre = 0;
                end
                1: if (m_pre == CLK_HZ - 1) begin
                    m_pre = 0;
                    m_cd--;
                    if (m_cd == 0) m_st = 2;
                end else m_pre++;
                2: begin
                    if (h && !m && m_sc < 255) m_sc++;
                    if (m && !h && m_sc > 0) m_sc--;
                    if (t && el >= GS) begin
                        m_st = 3; m_go = 1;
                        if (m_sc > m_best) m_best = m_sc;
                    end
                end
                default: ;
            endcase
        end
        m_ts = (m_st == 2) ? 1 : 0;
        if (m_st == 2) m_tl = (el >= GS) ? 0 : GS - el;
        else if (m_st == 3) m_tl = 0;
        else m_tl = GS;
        e.st = m_st; e.cd = m_cd; e.tl = m_tl; e.sc = m_sc;
        e.ts = m_ts; e.go = m_go; e.best = m_best;
        q.push_back(e);
    endtask

    task automatic cyc(input bit r, s, a, h, m, t);
        exp_t e;
        @(negedge clk);
        rst_n = r; start_btn = s; abort_btn = a;
        hit = h; miss = m; sec_tick = t;
        elapsed_time = 5'(tel);
        model(r, s, a, h, m, t, tel);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("state", int'(state), e.st);
        check("countdown", int'(countdown), e.cd);
        check("time_left", int'(time_left), e.tl);
        check("score", int'(score), e.sc);
        check("timer_start", int'(timer_start), e.ts);
        check("game_over", int'(game_over), e.go);
`ifdef BEST_SCORE_EN
        check("best_score", int'(best_score), e.best);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic play_round(input int hits);
        cyc(1, 1, 0, 0, 0, 0);
        idle(CS * CLK_HZ);
        for (int i = 0; i < hits; i++) cyc(1, 0, 0, 1, 0, 0);
    endtask

    task automatic finish_round();
        for (int i = 1; i <= GS; i++) begin
            tel = i;
            cyc(1, 0, 0, 0, 0, 1);
        end
        tel = 0;
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("rst_state", int'(state), 0);
        check("rst_time_left", int'(time_left), GS);
        idle(20);

        // countdown 2 at N+1, 1 at N+5, PLAY at N+9
        cyc(1, 1, 0, 0, 0, 0);
        check("cd_first", int'(countdown), 2);
        idle(4);
        check("cd_second", int'(countdown), 1);
        idle(3);
        check("still_cd", int'(state), 1);
        idle(1);
        check("play_entry", int'(state), 2);
        check("ts_entry", int'(timer_start), 1);

        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 1, 0);
        check("score_mix", int'(score), 3);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 0);
        check("score_floor", int'(score), 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0, 0);

        // ticks 1,2 then terminal tick with a hit
        tel = 1; cyc(1, 0, 0, 0, 0, 1);
        check("tl_after_1", int'(time_left), 2);
        cyc(1, 0, 0, 0, 0, 0);
        tel = 2; cyc(1, 0, 0, 0, 0, 1);
        check("tl_after_2", int'(time_left), 1);
        tel = 3; cyc(1, 0, 0, 1, 0, 1);
        tel = 0;
        check("over_state", int'(state), 3);
        check("over_pulse", int'(game_over), 1);
        check("over_score", int'(score), 5);
        cyc(1, 0, 0, 1, 0, 1);
        check("pulse_gone", int'(game_over), 0);
        check("score_held", int'(score), 5);

        cyc(1, 1, 1, 0, 0, 0);
        check("abort_wins", int'(state), 0);
        idle(2);

        // best-score rounds: 4 then 2, then abort at 9
        play_round(4);
        finish_round();
        idle(1);
        play_round(2);
        finish_round();
`ifdef BEST_SCORE_EN
        check("best_keep", int'(best_score), 4);
`endif
        play_round(9);
        cyc(1, 0, 1, 0, 0, 0);
`ifdef BEST_SCORE_EN
        check("best_abort", int'(best_score), 4);
`endif

        // reset mid-play
        play_round(3);
        cyc(0, 0, 0, 1, 0, 0);
        check("mid_rst_state", int'(state), 0);
        check("mid_rst_score", int'(score), 0);
        check("mid_rst_ts", int'(timer_start), 0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
